serial_div_detect: RTL



---
 rtl/serial_div_detect.sv | 121 ++++++++++++
 1 files changed

// File: rtl/serial_div_detect.sv
// Serial divisibility detector: tracks the running value of a bit stream modulo
// NUM_DIV fixed divisors and flags which divisors currently divide it.
module serial_div_detect #(
   parameter int                         NUM_DIV   = 5,
   parameter int                         DIV_W     = 4,
   parameter logic [NUM_DIV*DIV_W-1:0]   DIVISORS  = {4'd9, 4'd6, 4'd4, 4'd12, 4'd2},
   parameter int                         LSB_FIRST = 0,
   parameter int                         CNT_W     = 8
) (
   input  logic                       clk,
   input  logic                       rest,
   input  logic                       in_valid,
   input  logic                       in,
   input  logic                       clr,
   output logic [NUM_DIV-1:0]         div_hit,
   output logic [NUM_DIV*DIV_W-1:0]   rem_bus,
   output logic [CNT_W-1:0]           nbits,
   output logic                       nbits_sat
);

   localparam logic [DIV_W-1:0] ONE_W   = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [DIV_W-1:0] ZERO_W  = {DIV_W{1'b0}};
   localparam logic [DIV_W:0]   ZERO_W1 = {(DIV_W+1){1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   if (NUM_DIV < 1 || NUM_DIV > 16) begin : g_bad_num
      $error("serial_div_detect: NUM_DIV must be 1..16");
   end

   for (genvar g = 0; g < NUM_DIV; g++) begin : g_chk
      if (DIVISORS[g*DIV_W +: DIV_W] < 2) begin : g_bad_div
         $error("serial_div_detect: divisor channel %0d must be >= 2", g);
      end
   end

   // Reduce a value known to be below 2*d into [0, d).
   function automatic logic [DIV_W-1:0] mod_fold(input logic [DIV_W:0] v,
                                                input logic [DIV_W-1:0] d);
      logic [DIV_W:0] diff;
      diff = v - {1'b0, d};
      if (v >= {1'b0, d}) begin
         return diff[DIV_W-1:0];
      end else begin
         return v[DIV_W-1:0];
      end
   endfunction

   logic [DIV_W-1:0]   rem_q  [NUM_DIV];
   logic [DIV_W-1:0]   rem_d  [NUM_DIV];
   logic [DIV_W-1:0]   pw_q   [NUM_DIV];
   logic [DIV_W-1:0]   pw_d   [NUM_DIV];
   logic [DIV_W-1:0]   base_r [NUM_DIV];
   logic [DIV_W-1:0]   base_p [NUM_DIV];
   logic [NUM_DIV-1:0] hit_q, hit_d;
   logic [CNT_W-1:0]   nbits_q, nbits_d, base_n;
   logic               sat_q, sat_d;

   // Next-state: a clear restarts from the empty number, then the bit (if any) is folded in.
   always_comb begin
      for (int k = 0; k < NUM_DIV; k++) begin
         base_r[k] = clr ? ZERO_W : rem_q[k];
         base_p[k] = clr ? ONE_W  : pw_q[k];
         rem_d[k]  = base_r[k];
         pw_d[k]   = base_p[k];
         if (in_valid) begin
            if (LSB_FIRST != 0) begin
               rem_d[k] = mod_fold({1'b0, base_r[k]} + (in ? {1'b0, base_p[k]} : ZERO_W1),
                                   DIVISORS[k*DIV_W +: DIV_W]);
               pw_d[k]  = mod_fold({base_p[k], 1'b0}, DIVISORS[k*DIV_W +: DIV_W]);
            end else begin
               rem_d[k] = mod_fold({base_r[k], in}, DIVISORS[k*DIV_W +: DIV_W]);
               pw_d[k]  = base_p[k];
            end
         end else begin
            rem_d[k] = base_r[k];
            pw_d[k]  = base_p[k];
         end
         hit_d[k] = (rem_d[k] == ZERO_W);
      end

      base_n  = clr ? {CNT_W{1'b0}} : nbits_q;
      nbits_d = base_n;
      if (in_valid && (base_n != CNT_MAX)) begin
         nbits_d = base_n + CNT_ONE;
      end else begin
         nbits_d = base_n;
      end
      sat_d = (nbits_d == CNT_MAX);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rest) begin
         for (int k = 0; k < NUM_DIV; k++) begin
            rem_q[k] <= ZERO_W;
            pw_q[k]  <= ONE_W;
         end
         hit_q   <= {NUM_DIV{1'b1}};
         nbits_q <= {CNT_W{1'b0}};
         sat_q   <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_DIV; k++) begin
            rem_q[k] <= rem_d[k];
            pw_q[k]  <= pw_d[k];
         end
         hit_q   <= hit_d;
         nbits_q <= nbits_d;
         sat_q   <= sat_d;
      end
   end

   for (genvar g = 0; g < NUM_DIV; g++) begin : g_bus
      assign rem_bus[g*DIV_W +: DIV_W] = rem_q[g];
   end

   assign div_hit   = hit_q;
   assign nbits     = nbits_q;
   assign nbits_sat = sat_q;

endmodule
